seq_div: RTL and testbench

- Multi-cycle restoring divider; the inverse companion of the team's sequential multiplier (mul).
- Uses the same start/fin handshake: divides a 2W-bit dividend by a W-bit divisor and returns a 2W-bit quotient and a W-bit remainder.
- Produces one quotient bit per clock.
- Sits beside mul in the arithmetic datapath, and in the multiply-then-divide round-trip benches.

---
 rtl/div_pkg.sv | 21 ++
 rtl/seq_div_if.sv | 27 ++
 rtl/div_step.sv | 27 ++
 rtl/seq_div.sv | 122 ++++++++++++
 tb/tb_seq_div.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package div_pkg;

  // Controller states of the divider.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  // Default divisor width used where no instance parameter is in scope.
  localparam int DIV_W_DEFAULT = 8;

  // Step counter width: must hold 0 .. 2W-1 with one bit of headroom.
  function automatic int cnt_width(input int w);
    return $clog2(2 * w) + 1;
  endfunction

  localparam int CNT_W = cnt_width(DIV_W_DEFAULT);

endpackage

// File: rtl/seq_div_if.sv
// Operand/result bundle for seq_div: start/fin handshake plus data buses.
interface seq_div_if #(
  parameter int W = 8
) ();

  logic [2*W-1:0] N;
  logic [W-1:0]   D;
  logic           start;
  logic [2*W-1:0] Q;
  logic [W-1:0]   R;
  logic           dz;
  logic           fin;
  logic           busy;

  // Requester side: drives operands and start, observes results.
  modport master (
    output N, D, start,
    input  Q, R, dz, fin, busy
  );

  // Divider side: consumes operands, produces results and status.
  modport slave (
    input  N, D, start,
    output Q, R, dz, fin, busy
  );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep the difference if it did not go negative.
module div_step #(
  parameter int W = 8
) (
  input  logic [W-1:0] p_in,
  input  logic         bit_in,
  input  logic [W-1:0] d,
  output logic [W-1:0] p_out,
  output logic         q_bit
);

  logic [W:0] p_shift;

  // The shifted value needs W+1 bits; the kept remainder is always < d,
  // so it fits back into W bits and the top bit never needs storing.
  always_comb begin
    p_shift = {p_in, bit_in};
    q_bit   = 1'b0;
    p_out   = p_shift[W-1:0];
    if (p_shift >= {1'b0, d}) begin
      q_bit = 1'b1;
      p_out = p_shift[W-1:0] - d;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one
// quotient bit per clock, start/fin handshake, divide-by-zero flag.
module seq_div
  import div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic      ck,
  input  logic      rst,
  seq_div_if.slave  bus
);

  localparam int CW = cnt_width(W);
  localparam logic [CW-1:0] LAST_CNT = CW'(2 * W - 1);

  div_state_t     state_reg, state_next;
  logic [2*W-1:0] sr_reg;     // dividend shifting out, quotient shifting in
  logic [W-1:0]   d_reg;
  logic [W-1:0]   p_reg;      // partial remainder
  logic [CW-1:0]  cnt_reg;
  logic [2*W-1:0] q_reg;
  logic [W-1:0]   r_reg;
  logic           dz_reg;

  logic [W-1:0]   p_step;
  logic           q_bit;
  logic           last_step;
  logic           fin_o;
  logic           busy_o;

  div_step #(.W(W)) u_step (
    .p_in   (p_reg),
    .bit_in (sr_reg[2*W-1]),
    .d      (d_reg),
    .p_out  (p_step),
    .q_bit  (q_bit)
  );

  assign last_step = (cnt_reg == LAST_CNT);

  // State register.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a zero divisor skips the iteration entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.D == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state.
  always_comb begin
    fin_o  = (state_reg == DONE);
    busy_o = (state_reg != IDLE);
  end

  // Datapath: operand capture on accept, one restoring step per RUN cycle,
  // results committed only when an operation completes.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      sr_reg  <= '0;
      d_reg   <= '0;
      p_reg   <= '0;
      cnt_reg <= '0;
      q_reg   <= '0;
      r_reg   <= '0;
      dz_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sr_reg  <= bus.N;
            d_reg   <= bus.D;
            p_reg   <= '0;
            cnt_reg <= '0;
            if (bus.D == '0) begin
              q_reg  <= '1;
              r_reg  <= bus.N[W-1:0];
              dz_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          sr_reg  <= {sr_reg[2*W-2:0], q_bit};
          p_reg   <= p_step;
          cnt_reg <= cnt_reg + CW'(1);
          if (last_step) begin
            q_reg  <= {sr_reg[2*W-2:0], q_bit};
            r_reg  <= p_step;
            dz_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Q    = q_reg;
  assign bus.R    = r_reg;
  assign bus.dz   = dz_reg;
  assign bus.fin  = fin_o;
  assign bus.busy = busy_o;

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div: cycle-level behavioural model plus
// directed vectors with hand-computed results and a division round-trip.
module tb_seq_div;

  localparam int W = 8;
  localparam int LAT = 2 * W;

  logic ck  = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;
  int tb_cyc = 0;

  seq_div_if #(.W(W)) dif ();

  seq_div #(.W(W)) dut (
    .ck  (ck),
    .rst (rst),
    .bus (dif)
  );

  always #5 ck = ~ck;

  // Cycle counter for spacing measurements.
  always @(posedge ck) tb_cyc <= tb_cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model thinks only in terms of "when was the request taken, how
  // long does an answer take, what is N/D": results appear LAT edges after
  // the accept (0 for D==0) and the unit is free again two edges later.
  int             cyc      = 0;
  int             free_at  = 0;
  int             pend_fin = 0;
  logic           pend     = 1'b0;
  logic [15:0]    pq       = '0;
  logic [7:0]     pr       = '0;
  logic [15:0]    m_q      = '0;
  logic [7:0]     m_r      = '0;
  logic           m_dz     = 1'b0;
  logic           m_fin    = 1'b0;
  logic           m_busy   = 1'b0;

  // Model update on each rising edge (and on reset).
  always @(posedge ck or posedge rst) begin
    if (rst) begin
      cyc <= 0; free_at <= 0; pend <= 1'b0; pend_fin <= 0;
      m_q <= '0; m_r <= '0; m_dz <= 1'b0; m_fin <= 1'b0; m_busy <= 1'b0;
    end else begin
      m_fin <= 1'b0;
      if (pend && cyc == pend_fin) begin
        m_q <= pq; m_r <= pr; m_dz <= 1'b0; m_fin <= 1'b1; pend <= 1'b0;
      end
      if (cyc >= free_at && dif.start) begin
        m_busy <= 1'b1;
        if (dif.D == 8'd0) begin
          m_q <= 16'hFFFF; m_r <= dif.N[7:0]; m_dz <= 1'b1; m_fin <= 1'b1;
          free_at <= cyc + 2;
        end else begin
          pend <= 1'b1;
          pend_fin <= cyc + LAT;
          pq <= dif.N / {8'd0, dif.D};
          pr <= 8'(dif.N % {8'd0, dif.D});
          free_at <= cyc + LAT + 2;
        end
      end else begin
        m_busy <= (cyc <= free_at - 2);
      end
      cyc <= cyc + 1;
    end
  end

  // Compare process: every falling edge outside reset.
  always @(negedge ck) begin
    if (!rst) begin
      chk("cyc_fin",  {31'd0, dif.fin},  {31'd0, m_fin});
      chk("cyc_busy", {31'd0, dif.busy}, {31'd0, m_busy});
      chk("cyc_Q",    {16'd0, dif.Q},    {16'd0, m_q});
      chk("cyc_R",    {24'd0, dif.R},    {24'd0, m_r});
      chk("cyc_dz",   {31'd0, dif.dz},   {31'd0, m_dz});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle();
    for (int i = 0; i < 40 && dif.busy; i++) @(negedge ck);
    if (dif.busy) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issue one operation and return what the DUT shows while fin is high.
  task automatic run_op(input logic [15:0] n, input logic [7:0] d,
                        output logic [15:0] q, output logic [7:0] r,
                        output logic z, output int lat);
    wait_idle();
    dif.N = n; dif.D = d; dif.start = 1'b1;
    @(negedge ck);
    dif.start = 1'b0;
    dif.N = 16'($urandom);
    dif.D = 8'($urandom);
    lat = 0;
    while (!dif.fin && lat < 40) begin
      @(negedge ck);
      lat++;
    end
    q = dif.Q; r = dif.R; z = dif.dz;
    $display("op N=%h D=%h -> Q=%h R=%h dz=%b lat=%0d", n, d, q, r, z, lat);
  endtask

  task automatic directed(input string nm, input logic [15:0] n, input logic [7:0] d,
                          input logic [15:0] eq, input logic [7:0] er,
                          input logic ez, input int elat);
    logic [15:0] q;
    logic [7:0]  r;
    logic        z;
    int          lat;
    run_op(n, d, q, r, z, lat);
    chk({nm, "_lat"}, lat, elat);
    chk({nm, "_Q"},  {16'd0, q}, {16'd0, eq});
    chk({nm, "_R"},  {24'd0, r}, {24'd0, er});
    chk({nm, "_dz"}, {31'd0, z}, {31'd0, ez});
  endtask

  // Stop runaway simulations.
  initial begin
    #700000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  logic [15:0] q_o;
  logic [7:0]  r_o;
  logic        dz_o;
  int          lat_o;
  int          fins;
  int          rises;
  int          rise_cyc [3];
  logic        prev_busy;
  logic        rt_ok;
  int          kv, rv, nv;

  // Main directed sequence.
  initial begin
    dif.N = '0; dif.D = '0; dif.start = 1'b0;
    repeat (3) @(negedge ck);
    chk("rst_Q",    {16'd0, dif.Q}, 32'd0);
    chk("rst_R",    {24'd0, dif.R}, 32'd0);
    chk("rst_busy", {31'd0, dif.busy}, 32'd0);
    chk("rst_fin",  {31'd0, dif.fin}, 32'd0);
    rst = 1'b0;
    @(negedge ck);

    // 0x1234 = 4660 = 7*665 + 5
    directed("basic",  16'h1234, 8'h07, 16'h0299, 8'h05, 1'b0, 16);

    // Reset in the middle of an operation.
    wait_idle();
    dif.N = 16'h1234; dif.D = 8'h07; dif.start = 1'b1;
    @(negedge ck);
    dif.start = 1'b0;
    repeat (4) @(negedge ck);
    rst = 1'b1;
    #1;
    chk("midrst_Q",    {16'd0, dif.Q}, 32'd0);
    chk("midrst_R",    {24'd0, dif.R}, 32'd0);
    chk("midrst_busy", {31'd0, dif.busy}, 32'd0);
    chk("midrst_fin",  {31'd0, dif.fin}, 32'd0);
    @(negedge ck);
    @(negedge ck);
    rst = 1'b0;
    fins = 0;
    for (int i = 0; i < 24; i++) begin
      @(negedge ck);
      if (dif.fin) fins++;
    end
    chk("midrst_nofin", fins, 0);

    directed("ffff_1", 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 16);
    directed("0_ff",   16'h0000, 8'hFF, 16'h0000, 8'h00, 1'b0, 16);
    directed("fe_ff",  16'h00FE, 8'hFF, 16'h0000, 8'hFE, 1'b0, 16);
    directed("dz",     16'hABCD, 8'h00, 16'hFFFF, 8'hCD, 1'b1, 0);
    directed("dzclr",  16'h0005, 8'h02, 16'h0002, 8'h01, 1'b0, 16);

    // A start pulse during RUN must be ignored.
    wait_idle();
    dif.N = 16'h1234; dif.D = 8'h07; dif.start = 1'b1;
    @(negedge ck);
    dif.start = 1'b0;
    repeat (5) @(negedge ck);
    dif.N = 16'hFFFF; dif.D = 8'h01; dif.start = 1'b1;
    @(negedge ck);
    dif.start = 1'b0;
    for (int i = 0; i < 40 && !dif.fin; i++) @(negedge ck);
    chk("pulse_fin", {31'd0, dif.fin}, 32'd1);
    chk("pulse_Q",   {16'd0, dif.Q}, 32'h0299);
    chk("pulse_R",   {24'd0, dif.R}, 32'h05);
    $display("op pulse-ignored Q=%h R=%h", dif.Q, dif.R);
    repeat (3) @(negedge ck);
    chk("pulse_nobusy", {31'd0, dif.busy}, 32'd0);

    // Start held high: one operation every 2W+2 cycles, operand noise
    // while busy must not disturb results.
    wait_idle();
    dif.N = 16'h1234; dif.D = 8'h07; dif.start = 1'b1;
    prev_busy = 1'b0; rises = 0; fins = 0;
    for (int i = 0; i < 3 * (LAT + 2); i++) begin
      @(negedge ck);
      if (dif.busy && !prev_busy) begin
        if (rises < 3) rise_cyc[rises] = tb_cyc;
        rises++;
      end
      if (dif.fin) begin
        fins++;
        chk("b2b_Q", {16'd0, dif.Q}, 32'h0299);
        chk("b2b_R", {24'd0, dif.R}, 32'h05);
        $display("op b2b Q=%h R=%h at cyc %0d", dif.Q, dif.R, tb_cyc);
      end
      prev_busy = dif.busy;
      if (dif.busy) begin
        dif.N = 16'($urandom); dif.D = 8'($urandom);
      end else begin
        dif.N = 16'h1234; dif.D = 8'h07;
      end
    end
    dif.start = 1'b0;
    chk("b2b_rises", rises, 3);
    chk("b2b_fins",  fins, 3);
    chk("b2b_gap0",  rise_cyc[1] - rise_cyc[0], LAT + 2);
    chk("b2b_gap1",  rise_cyc[2] - rise_cyc[1], LAT + 2);

    // Round-trip: N = D*k + r must come back as Q=k, R=r.
    rt_ok = 1'b1;
    for (int dv = 1; dv < 256 && rt_ok; dv++) begin
      for (int ki = 0; ki < 3 && rt_ok; ki++) begin
        for (int ri = 0; ri < 2 && rt_ok; ri++) begin
          kv = (ki == 0) ? 0 : ((ki == 1) ? 1 : 255);
          rv = (ri == 0) ? 0 : dv - 1;
          nv = dv * kv + rv;
          run_op(16'(nv), 8'(dv), q_o, r_o, dz_o, lat_o);
          total++;
          if (q_o !== 16'(kv) || r_o !== 8'(rv) || dz_o !== 1'b0 || lat_o != LAT) begin
            bad++;
            rt_ok = 1'b0;
            $display("FAIL roundtrip N=%0d D=%0d: got Q=%0d R=%0d dz=%b lat=%0d want Q=%0d R=%0d dz=0 lat=%0d",
                     nv, dv, q_o, r_o, dz_o, lat_o, kv, rv, LAT);
          end
        end
      end
    end
    if (rt_ok) $display("round-trip OK");

    repeat (4) @(negedge ck);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
